// File: rtl/valu_issue_queue_pkg.sv
// Shared types for the vector ALU issue queue: vreg/opcode types, queue entry struct, defaults.
// VALU_SCALAR_BCAST_EN adds a scalar flag and 16-bit scalar to each entry.
package valu_issue_queue_pkg;

  localparam int NUM_ELEMENTS  = 4;
  localparam int FP_W          = 16;
  localparam int VIQ_DEPTH_DEF = 4;
  localparam int VALU_LAT_DEF  = 2;

  typedef logic [4:0]                         vsel_t;
  typedef logic [NUM_ELEMENTS-1:0][FP_W-1:0]  vreg_t;
  typedef logic [NUM_ELEMENTS-1:0]            vmask_t;

  typedef enum logic [3:0] {
    VOP_ADD = 4'd0,
    VOP_SUB = 4'd1,
    VOP_MUL = 4'd2,
    VOP_MAX = 4'd3,
    VOP_MIN = 4'd4,
    VOP_MOV = 4'd5
  } opcode_t;

  typedef struct packed {
    opcode_t     vop;
    vreg_t       v1;
    vreg_t       v2;
    vmask_t      vmask;
    vsel_t       vd;
`ifdef VALU_SCALAR_BCAST_EN
    logic        scalar;
    logic [15:0] s16;
`endif
  } valu_issue_t;

  // Replicates one FP16 scalar into every lane of a vector register.
  function automatic vreg_t bcast16(input logic [FP_W-1:0] s);
    vreg_t r;
    for (int l = 0; l < NUM_ELEMENTS; l++) r[l] = s;
    return r;
  endfunction

endpackage

// File: rtl/valu_issue_queue_if.sv
// Decode-side enqueue, VALU operand and writeback signals of the issue queue.
// The slave modport is the queue; the master modport is decode/VALU/writeback.
interface valu_issue_queue_if
  import valu_issue_queue_pkg::*;
#(
  parameter int DEPTH = VIQ_DEPTH_DEF
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             enq_valid;
  logic             enq_ready;
  opcode_t          enq_vop;
  vreg_t            enq_v1;
  vreg_t            enq_v2;
  vmask_t           enq_vmask;
  vsel_t            enq_vd;
  logic             enq_scalar;
  logic [31:0]      enq_r1;
  logic             flush;
  logic             wb_stall;
  logic             valu_issue;
  vreg_t            vdat1;
  vreg_t            vdat2;
  opcode_t          vop;
  vmask_t           vmask;
  logic             wb_valid;
  vsel_t            wb_vd;
  logic [CNT_W-1:0] count;

  modport slave (
    input  enq_valid, enq_vop, enq_v1, enq_v2, enq_vmask, enq_vd, enq_scalar, enq_r1,
    input  flush, wb_stall,
    output enq_ready, valu_issue, vdat1, vdat2, vop, vmask, wb_valid, wb_vd, count
  );

  modport master (
    output enq_valid, enq_vop, enq_v1, enq_v2, enq_vmask, enq_vd, enq_scalar, enq_r1,
    output flush, wb_stall,
    input  enq_ready, valu_issue, vdat1, vdat2, vop, vmask, wb_valid, wb_vd, count
  );

endinterface

// File: rtl/valu_inflight_pipe.sv
// Fixed-latency shadow of the VALU pipeline: carries {valid, vd} so writeback gets the
// destination register in the same cycle as the VALU result. Never stalls.
module valu_inflight_pipe
  import valu_issue_queue_pkg::*;
#(
  parameter int LAT = VALU_LAT_DEF
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  issue_i,
  input  vsel_t vd_i,
  output logic  wb_valid_o,
  output vsel_t wb_vd_o
);

  logic [LAT-1:0] valid_q;
  vsel_t          vd_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s < LAT; s++) vd_q[s] <= '0;
    end else begin
      valid_q[0] <= issue_i;
      vd_q[0]    <= vd_i;
      for (int s = 1; s < LAT; s++) begin
        valid_q[s] <= valid_q[s-1];
        vd_q[s]    <= vd_q[s-1];
      end
    end
  end

  assign wb_valid_o = valid_q[LAT-1];
  assign wb_vd_o    = vd_q[LAT-1];

endmodule

// File: rtl/valu_issue_queue.sv
// Issue queue between vector decode and the VALU, with in-flight tracking for writeback.
// Optional VALU_SCALAR_BCAST_EN: vector-scalar ops broadcast r1[15:0] into every lane of vdat2.
module valu_issue_queue
  import valu_issue_queue_pkg::*;
#(
  parameter int DEPTH    = VIQ_DEPTH_DEF,
  parameter int VALU_LAT = VALU_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  valu_issue_queue_if.slave  bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  valu_issue_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  valu_issue_t      enq_entry;
  valu_issue_t      head;
  logic             empty;
  logic             full;
  logic             enq_fire;
  logic             issue;
  vsel_t            issue_vd;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign head     = mem_q[rd_ptr_q];
  assign issue    = !empty && !bus.wb_stall && !bus.flush;
  assign enq_fire = bus.enq_valid && bus.enq_ready;
  assign issue_vd = issue ? head.vd : '0;

  assign bus.enq_ready = !full && !bus.flush;
  assign bus.count     = count_q;

  always_comb begin
    enq_entry.vop   = bus.enq_vop;
    enq_entry.v1    = bus.enq_v1;
    enq_entry.v2    = bus.enq_v2;
    enq_entry.vmask = bus.enq_vmask;
    enq_entry.vd    = bus.enq_vd;
`ifdef VALU_SCALAR_BCAST_EN
    enq_entry.scalar = bus.enq_scalar;
    enq_entry.s16    = bus.enq_r1[15:0];
`endif
  end

`ifdef VALU_SCALAR_BCAST_EN
  logic unused_r1_hi;
  assign unused_r1_hi = ^bus.enq_r1[31:16];
`else
  logic unused_scalar;
  assign unused_scalar = ^{bus.enq_scalar, bus.enq_r1};
`endif

  // Flush wins over any enqueue or pop in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
      if (issue)    rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(enq_fire) - CNT_W'(issue);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem_q[wr_ptr_q] <= enq_entry;
  end

  // Operand lines are held at zero whenever nothing issues.
  always_comb begin
    bus.valu_issue = issue;
    bus.vdat1      = '0;
    bus.vdat2      = '0;
    bus.vop        = VOP_ADD;
    bus.vmask      = '0;
    if (issue) begin
      bus.vdat1 = head.v1;
      bus.vdat2 = head.v2;
      bus.vop   = head.vop;
      bus.vmask = head.vmask;
`ifdef VALU_SCALAR_BCAST_EN
      if (head.scalar) bus.vdat2 = bcast16(head.s16);
`endif
    end
  end

  valu_inflight_pipe #(
    .LAT (VALU_LAT)
  ) u_inflight (
    .clk        (clk),
    .rst_n      (rst_n),
    .issue_i    (issue),
    .vd_i       (issue_vd),
    .wb_valid_o (bus.wb_valid),
    .wb_vd_o    (bus.wb_vd)
  );

endmodule

// File: tb/tb_valu_issue_queue.sv
// Directed self-checking bench for valu_issue_queue (DEPTH=4, VALU_LAT=2).
// Checks reset, latency, fill/backpressure, pointer wrap, flush and vdat2 source.
module tb_valu_issue_queue;
  import valu_issue_queue_pkg::*;

  localparam logic [63:0] V1_BASE = 64'h1000_2000_3000_4000;
  localparam logic [63:0] V2_BASE = 64'h0A0B_0C0D_0E0F_0000;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  valu_issue_queue_if #(.DEPTH(4)) bus ();

  valu_issue_queue #(
    .DEPTH    (4),
    .VALU_LAT (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one cycle of inputs; operand data is derived from vd so each op is distinct.
  task automatic applyStimulus(input logic valid, input int vd, input logic stall,
                               input logic fl);
    bus.enq_valid = valid;
    bus.enq_vd    = vsel_t'(vd);
    bus.enq_vop   = VOP_MUL;
    bus.enq_v1    = V1_BASE + 64'(vd);
    bus.enq_v2    = V2_BASE + 64'(vd);
    bus.enq_vmask = vmask_t'(vd) ^ 4'b1010;
    bus.wb_stall  = stall;
    bus.flush     = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    clk            = 1'b0;
    rst_n          = 1'b0;
    bus.enq_scalar = 1'b0;
    bus.enq_r1     = '0;
    applyStimulus(0, 0, 0, 0);
    tick();
    tick();
    checkOutput("rst_enq_ready", 64'(bus.enq_ready), 64'd1);
    checkOutput("rst_issue", 64'(bus.valu_issue), 64'd0);
    checkOutput("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    checkOutput("rst_wb_vd", 64'(bus.wb_vd), 64'd0);
    checkOutput("rst_count", 64'(bus.count), 64'd0);
    checkOutput("rst_vdat1", 64'(bus.vdat1), 64'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] single op latency");
    applyStimulus(1, 3, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("single_issue", 64'(bus.valu_issue), 64'd1);
    checkOutput("single_count", 64'(bus.count), 64'd1);
    checkOutput("single_vdat1", 64'(bus.vdat1), 64'h1000_2000_3000_4003);
    checkOutput("single_vdat2", 64'(bus.vdat2), 64'h0A0B_0C0D_0E0F_0003);
    checkOutput("single_vmask", 64'(bus.vmask), 64'b1001);
    checkOutput("single_vop", 64'(bus.vop), 64'd2);
    checkOutput("single_wb_early", 64'(bus.wb_valid), 64'd0);
    tick();
    checkOutput("single_issue_done", 64'(bus.valu_issue), 64'd0);
    checkOutput("single_vdat1_zero", 64'(bus.vdat1), 64'd0);
    checkOutput("single_wb_mid", 64'(bus.wb_valid), 64'd0);
    tick();
    checkOutput("single_wb_valid", 64'(bus.wb_valid), 64'd1);
    checkOutput("single_wb_vd", 64'(bus.wb_vd), 64'd3);
    tick();
    checkOutput("single_wb_gone", 64'(bus.wb_valid), 64'd0);

    $display("[TB] fill under stall");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, i, 1, 0);
      tick();
    end
    applyStimulus(1, 4, 1, 0);
    checkOutput("fill_count", 64'(bus.count), 64'd4);
    checkOutput("fill_ready", 64'(bus.enq_ready), 64'd0);
    checkOutput("fill_stall_issue", 64'(bus.valu_issue), 64'd0);
    tick();
    applyStimulus(1, 4, 0, 0);
    checkOutput("fill_5th_refused", 64'(bus.count), 64'd4);
    checkOutput("fill_release_issue", 64'(bus.valu_issue), 64'd1);
    checkOutput("fill_no_passthru", 64'(bus.enq_ready), 64'd0);
    checkOutput("fill_head0", 64'(bus.vdat1), V1_BASE + 64'd0);
    tick();
    applyStimulus(1, 4, 0, 0);
    checkOutput("fill_count_c1", 64'(bus.count), 64'd3);
    checkOutput("fill_ready_c1", 64'(bus.enq_ready), 64'd1);
    checkOutput("fill_head1", 64'(bus.vdat1), V1_BASE + 64'd1);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("fill_count_c2", 64'(bus.count), 64'd3);
    checkOutput("fill_wb0_valid", 64'(bus.wb_valid), 64'd1);
    checkOutput("fill_wb0", 64'(bus.wb_vd), 64'd0);
    tick();
    checkOutput("fill_wb1", 64'(bus.wb_vd), 64'd1);
    checkOutput("fill_count_c3", 64'(bus.count), 64'd2);
    tick();
    checkOutput("fill_wb2", 64'(bus.wb_vd), 64'd2);
    tick();
    checkOutput("fill_wb3", 64'(bus.wb_vd), 64'd3);
    checkOutput("fill_count_c5", 64'(bus.count), 64'd0);
    tick();
    checkOutput("fill_wb4_valid", 64'(bus.wb_valid), 64'd1);
    checkOutput("fill_wb4", 64'(bus.wb_vd), 64'd4);
    tick();
    checkOutput("fill_wb_idle", 64'(bus.wb_valid), 64'd0);

    $display("[TB] back-to-back with pointer wrap");
    applyStimulus(1, 5, 0, 0);
    tick();
    for (int i = 1; i < 16; i++) begin
      applyStimulus(1, i + 5, 0, 0);
      checkOutput("b2b_count", 64'(bus.count), 64'd1);
      checkOutput("b2b_issue", 64'(bus.valu_issue), 64'd1);
      checkOutput("b2b_vdat1", 64'(bus.vdat1), V1_BASE + 64'(i + 4));
      if (i >= 3) begin
        checkOutput("b2b_wb_valid", 64'(bus.wb_valid), 64'd1);
        checkOutput("b2b_wb_vd", 64'(bus.wb_vd), 64'(i + 2));
      end
      tick();
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("b2b_tail_count", 64'(bus.count), 64'd1);
    checkOutput("b2b_tail_wb", 64'(bus.wb_vd), 64'd18);
    tick();
    checkOutput("b2b_drain_count", 64'(bus.count), 64'd0);
    checkOutput("b2b_drain_wb", 64'(bus.wb_vd), 64'd19);
    tick();
    checkOutput("b2b_last_valid", 64'(bus.wb_valid), 64'd1);
    checkOutput("b2b_last_wb", 64'(bus.wb_vd), 64'd20);
    tick();
    checkOutput("b2b_idle", 64'(bus.wb_valid), 64'd0);

    $display("[TB] flush");
    for (int i = 10; i < 14; i++) begin
      applyStimulus(1, i, 1, 0);
      tick();
    end
    applyStimulus(0, 0, 0, 0);
    checkOutput("flush_pre_issue", 64'(bus.valu_issue), 64'd1);
    tick();
    applyStimulus(1, 20, 0, 1);
    checkOutput("flush_pre_count", 64'(bus.count), 64'd3);
    checkOutput("flush_no_issue", 64'(bus.valu_issue), 64'd0);
    checkOutput("flush_not_ready", 64'(bus.enq_ready), 64'd0);
    tick();
    applyStimulus(0, 0, 0, 0);
    checkOutput("flush_count", 64'(bus.count), 64'd0);
    checkOutput("flush_inflight_valid", 64'(bus.wb_valid), 64'd1);
    checkOutput("flush_inflight_vd", 64'(bus.wb_vd), 64'd10);
    checkOutput("flush_idle_issue", 64'(bus.valu_issue), 64'd0);
    tick();
    checkOutput("flush_drop_count", 64'(bus.count), 64'd0);
    checkOutput("flush_wb_done", 64'(bus.wb_valid), 64'd0);

    $display("[TB] scalar operand source");
    bus.enq_scalar = 1'b1;
    bus.enq_r1     = 32'h0000_3C00;
    applyStimulus(1, 7, 0, 0);
    tick();
    bus.enq_scalar = 1'b0;
    bus.enq_r1     = '0;
    applyStimulus(0, 0, 0, 0);
    checkOutput("scalar_issue", 64'(bus.valu_issue), 64'd1);
`ifdef VALU_SCALAR_BCAST_EN
    checkOutput("scalar_vdat2", 64'(bus.vdat2), 64'h3C00_3C00_3C00_3C00);
`else
    checkOutput("scalar_vdat2", 64'(bus.vdat2), 64'h0A0B_0C0D_0E0F_0007);
`endif
    checkOutput("scalar_vmask", 64'(bus.vmask), 64'b1101);
    tick();
    tick();
    checkOutput("scalar_wb_vd", 64'(bus.wb_vd), 64'd7);
    tick();

    $display("[TB] reset mid-traffic");
    applyStimulus(1, 9, 0, 0);
    tick();
    applyStimulus(1, 11, 0, 0);
    tick();
    checkOutput("midrst_busy", 64'(bus.count), 64'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ready", 64'(bus.enq_ready), 64'd1);
    checkOutput("midrst_issue", 64'(bus.valu_issue), 64'd0);
    checkOutput("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
    checkOutput("midrst_count", 64'(bus.count), 64'd0);
    applyStimulus(0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("midrst_lost_0", 64'(bus.wb_valid), 64'd0);
    tick();
    checkOutput("midrst_lost_1", 64'(bus.wb_valid), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
